// File: rtl/branch_sequencer.sv
// branch_sequencer: fetches 16-bit control words and drives PC control.
// Optional loop counter (LDC/DJNZ) enabled by `BRANCH_SEQ_LOOP_COUNTER_EN.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_addr             current PC address
//   imem_rd_en/addr     instruction read request and registered address
//   imem_ready/rdata    read data valid and instruction word
//   cmp_data            external value compared by CMP
//   resume              leaves HALT
//   jump_control        PC control (00 inc, 01 hold, 10 cond load, 11 load)
//   eq_flag, load_data  compare result and jump target
//   roll_over           one-cycle PC wrap pulse
//   halted, illegal_op  HALT status and undefined-opcode pulse
module branch_sequencer #(
    parameter int LOOP_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pc_addr,
    output logic        imem_rd_en,
    output logic [11:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    input  logic [11:0] cmp_data,
    input  logic        resume,
    output logic [1:0]  jump_control,
    output logic        eq_flag,
    output logic [11:0] load_data,
    output logic        roll_over,
    output logic        halted,
    output logic        illegal_op
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_JEQ  = 4'd3;
    localparam logic [3:0] OP_LDC  = 4'd4;
    localparam logic [3:0] OP_DJNZ = 4'd5;
    localparam logic [3:0] OP_RST  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    localparam logic [1:0] JC_INC  = 2'b00;
    localparam logic [1:0] JC_HOLD = 2'b01;
    localparam logic [1:0] JC_COND = 2'b10;
    localparam logic [1:0] JC_LOAD = 2'b11;

    state_t      state;
    logic [15:0] ir;
    logic [3:0]  op;
    logic [11:0] operand;

    assign op      = imem_rdata[15:12];
    assign operand = imem_rdata[11:0];

`ifdef BRANCH_SEQ_LOOP_COUNTER_EN
    logic [LOOP_W-1:0] counter;
    logic [LOOP_W-1:0] cnt_dec;

    // Decrement wraps modulo 2^LOOP_W, so DJNZ from 0 jumps.
    assign cnt_dec = counter - LOOP_W'(1);
`endif

    // Decoded outputs are registered on the WAIT->ISSUE edge so they are
    // valid for exactly the ISSUE cycle; the flag updates land at its end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FETCH;
            ir           <= '0;
            imem_rd_en   <= 1'b0;
            imem_addr    <= '0;
            jump_control <= JC_HOLD;
            load_data    <= '0;
            eq_flag      <= 1'b0;
            roll_over    <= 1'b0;
            halted       <= 1'b0;
            illegal_op   <= 1'b0;
`ifdef BRANCH_SEQ_LOOP_COUNTER_EN
            counter      <= '0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    imem_addr    <= pc_addr;
                    imem_rd_en   <= 1'b1;
                    jump_control <= JC_HOLD;
                    roll_over    <= 1'b0;
                    illegal_op   <= 1'b0;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_ready) begin
                        imem_rd_en <= 1'b0;
                        ir         <= imem_rdata;
                        state      <= S_ISSUE;
                        case (op)
                            OP_NOP: jump_control <= JC_INC;
                            OP_JMP: begin
                                jump_control <= JC_LOAD;
                                load_data    <= operand;
                            end
                            OP_CMP: jump_control <= JC_INC;
                            OP_JEQ: begin
                                jump_control <= JC_COND;
                                load_data    <= operand;
                            end
`ifdef BRANCH_SEQ_LOOP_COUNTER_EN
                            OP_LDC: begin
                                jump_control <= JC_INC;
                                counter      <= operand[LOOP_W-1:0];
                            end
                            OP_DJNZ: begin
                                counter <= cnt_dec;
                                if (cnt_dec != '0) begin
                                    jump_control <= JC_LOAD;
                                    load_data    <= operand;
                                end else begin
                                    jump_control <= JC_INC;
                                end
                            end
`endif
                            OP_RST: begin
                                jump_control <= JC_HOLD;
                                roll_over    <= 1'b1;
`ifdef BRANCH_SEQ_LOOP_COUNTER_EN
                                counter      <= '0;
`endif
                            end
                            OP_HALT: jump_control <= JC_HOLD;
                            default: begin
                                jump_control <= JC_INC;
                                illegal_op   <= 1'b1;
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    jump_control <= JC_HOLD;
                    roll_over    <= 1'b0;
                    illegal_op   <= 1'b0;
                    // CMP samples cmp_data here so a following JEQ sees it.
                    if (ir[15:12] == OP_CMP) begin
                        eq_flag <= (ir[11:0] == cmp_data);
                    end else if (ir[15:12] == OP_RST) begin
                        eq_flag <= 1'b0;
                    end
                    if (ir[15:12] == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state  <= S_FETCH;
                    end
                end
                S_HALT: begin
                    jump_control <= JC_HOLD;
                    if (resume) begin
                        halted <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Testbench for branch_sequencer: table-driven instruction stream with a
// scoreboard queue, plus hand-written HALT/resume and reset-in-WAIT cases.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pc_addr;
    logic        imem_rd_en;
    logic [11:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [11:0] cmp_data;
    logic        resume;
    logic [1:0]  jump_control;
    logic        eq_flag;
    logic [11:0] load_data;
    logic        roll_over;
    logic        halted;
    logic        illegal_op;

    always #5 clk = ~clk;

    branch_sequencer #(.LOOP_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_addr      (pc_addr),
        .imem_rd_en   (imem_rd_en),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .cmp_data     (cmp_data),
        .resume       (resume),
        .jump_control (jump_control),
        .eq_flag      (eq_flag),
        .load_data    (load_data),
        .roll_over    (roll_over),
        .halted       (halted),
        .illegal_op   (illegal_op)
    );

`ifdef BRANCH_SEQ_LOOP_COUNTER_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    typedef struct {
        logic [15:0] word;
        int          waits;
        logic [11:0] cmp;
        logic [1:0]  jc;
        logic        ro;
        logic        ill;
        logic        eq;
        logic        hlt;
    } vec_t;

    typedef struct {
        logic [1:0]  jc;
        logic [11:0] ld;
        logic        ro;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [11:0] m_ld;
    logic        m_eq;
    logic [11:0] pc;
    vec_t        tbl[17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Entered at the negedge of a FETCH cycle; returns at the negedge of
    // the cycle following ISSUE.
    task automatic run(input vec_t v);
        int   n;
        bit   got;
        exp_t e;
        pc       = pc + 12'd1;
        pc_addr  = pc;
        cmp_data = v.cmp;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (imem_rd_en) got = 1'b1;
        end
        chk("rd_en_rise", 32'(got), 32'd1);
        if (!got) return;
        chk("fetch_to_wait", n, 1);
        chk("imem_addr", 32'(imem_addr), 32'(pc));
        for (int i = 0; i < v.waits; i++) begin
            imem_ready = 1'b0;
            @(negedge clk);
            n++;
            chk("wait_hold", {30'd0, imem_rd_en, jump_control == 2'b01}, 32'd3);
        end
        imem_ready = 1'b1;
        imem_rdata = v.word;
        if (v.jc == 2'b10 || v.jc == 2'b11) m_ld = v.word[11:0];
        e.jc  = v.jc;
        e.ld  = m_ld;
        e.ro  = v.ro;
        e.ill = v.ill;
        sb.push_back(e);
        @(negedge clk);
        n++;
        imem_ready = 1'b0;
        imem_rdata = 16'hFFFF;
        e = sb.pop_front();
        chk("issue_jc", 32'(jump_control), 32'(e.jc));
        chk("issue_ld", 32'(load_data), 32'(e.ld));
        chk("issue_ro", 32'(roll_over), 32'(e.ro));
        chk("issue_ill", 32'(illegal_op), 32'(e.ill));
        chk("issue_eq", 32'(eq_flag), 32'(m_eq));
        chk("issue_lat", n, 2 + v.waits);
        m_eq = v.eq;
        @(negedge clk);
        chk("post_jc", 32'(jump_control), 32'd1);
        chk("post_pulses", {30'd0, roll_over, illegal_op}, 32'd0);
        chk("post_eq", 32'(eq_flag), 32'(m_eq));
        chk("post_halted", 32'(halted), 32'(v.hlt));
    endtask

    initial begin
        tbl[0]  = '{16'h102D, 2, 12'd0,   2'b11, 0, 0, 0, 0};
        tbl[1]  = '{16'h2004, 0, 12'd4,   2'b00, 0, 0, 1, 0};
        tbl[2]  = '{16'h3010, 0, 12'd4,   2'b10, 0, 0, 1, 0};
        tbl[3]  = '{16'h2004, 1, 12'd5,   2'b00, 0, 0, 0, 0};
        tbl[4]  = '{16'h3010, 0, 12'd5,   2'b10, 0, 0, 0, 0};
        tbl[5]  = '{16'h4003, 0, 12'd0,   2'b00, 0, !CNT, 0, 0};
        tbl[6]  = '{16'h5020, 0, 12'd0,   CNT ? 2'b11 : 2'b00, 0, !CNT, 0, 0};
        tbl[7]  = '{16'h5020, 1, 12'd0,   CNT ? 2'b11 : 2'b00, 0, !CNT, 0, 0};
        tbl[8]  = '{16'h5020, 0, 12'd0,   2'b00, 0, !CNT, 0, 0};
        tbl[9]  = '{16'h0000, 3, 12'd0,   2'b00, 0, 0, 0, 0};
        tbl[10] = '{16'h9000, 0, 12'd0,   2'b00, 0, 1, 0, 0};
        tbl[11] = '{16'hF123, 0, 12'd0,   2'b00, 0, 1, 0, 0};
        tbl[12] = '{16'h2ABC, 0, 12'hABC, 2'b00, 0, 0, 1, 0};
        tbl[13] = '{16'h6000, 0, 12'd0,   2'b01, 1, 0, 0, 0};
        tbl[14] = '{16'h5040, 0, 12'd0,   CNT ? 2'b11 : 2'b00, 0, !CNT, 0, 0};
        tbl[15] = '{16'h2FFF, 0, 12'hFFF, 2'b00, 0, 0, 1, 0};
        tbl[16] = '{16'h7000, 0, 12'd0,   2'b01, 0, 0, 1, 1};

        rst        = 1'b1;
        pc_addr    = 12'd0;
        imem_ready = 1'b0;
        imem_rdata = 16'd0;
        cmp_data   = 12'd0;
        resume     = 1'b0;
        m_ld       = 12'd0;
        m_eq       = 1'b0;
        pc         = 12'hFFF;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_jc", 32'(jump_control), 32'd1);
            chk("rst_outs", {imem_rd_en, imem_addr, load_data, eq_flag,
                             roll_over, halted, illegal_op}, 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 17; i++) run(tbl[i]);

        // HALT: stays put, ignores imem_ready, leaves on resume.
        for (int i = 0; i < 10; i++) begin
            imem_ready = 1'b1;
            @(negedge clk);
            chk("halt_hold", {29'd0, halted, jump_control, imem_rd_en},
                32'b1010);
        end
        imem_ready = 1'b0;
        resume     = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        chk("resume_fetch", {30'd0, halted, imem_rd_en}, 32'd0);
        run('{16'h0000, 0, 12'd0, 2'b00, 0, 0, 1, 0});

        // Reset while waiting on memory; late ready must not issue.
        pc_addr = pc + 12'd1;
        @(negedge clk);
        chk("rw_rd_en", 32'(imem_rd_en), 32'd1);
        @(negedge clk);
        rst        = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 16'h102D;
        @(negedge clk);
        chk("rw_jc", 32'(jump_control), 32'd1);
        chk("rw_outs", {imem_rd_en, imem_addr, load_data, eq_flag,
                        roll_over, halted, illegal_op}, 32'd0);
        rst  = 1'b0;
        m_ld = 12'd0;
        m_eq = 1'b0;
        @(negedge clk);
        chk("late_ready", {29'd0, imem_rd_en, jump_control}, 32'b101);
        imem_rdata = 16'h1055;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("after_rst_jc", 32'(jump_control), 32'd3);
        chk("after_rst_ld", 32'(load_data), 32'h055);
        @(negedge clk);
        chk("after_rst_post", 32'(jump_control), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
